// File: rtl/filtr_pkg.sv
// Shared sizing and types for the input filter and the I/O image register.
package filtr_pkg;

  localparam int N_BYTES         = 8;
  localparam int N_BITS          = 8 * N_BYTES;
  localparam int DEBOUNCE_CYCLES = 16;
  localparam int CNT_W           = 8;

  typedef logic [N_BYTES-1:0][7:0] byte_arr_t;

endpackage

// File: rtl/filtr_wejsc_debounce_bit.sv
// One input bit: 2-flop synchronizer plus tick-driven debounce counter.
// Latency 2 clk + DEBOUNCE_CYCLES ticks; no backpressure, flip_strobe marks the flip edge.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic sample_tick,
  output logic filt_bit,
  output logic flip_strobe
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  assign flip_strobe = sample_tick && (s2 != filt_bit) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      cnt      <= '0;
      filt_bit <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (sample_tick) begin
        if (s2 == filt_bit) begin
          cnt <= '0;
        end else if (flip_strobe) begin
          filt_bit <= s2;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/filtr_wejsc.sv
// Debounced 64-bit field input stage; latency 2 clk + DEBOUNCE_CYCLES ticks, no backpressure.
// Optional sticky edge flags cleared by scan_ack when FILTR_EDGE_DETECT_EN is defined.
module filtr_wejsc
  import filtr_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = filtr_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = filtr_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  raw0,
  input  logic [7:0]  raw1,
  input  logic [7:0]  raw2,
  input  logic [7:0]  raw3,
  input  logic [7:0]  raw4,
  input  logic [7:0]  raw5,
  input  logic [7:0]  raw6,
  input  logic [7:0]  raw7,
  input  logic        sample_tick,
  input  logic        scan_ack,
  output logic [7:0]  filt0,
  output logic [7:0]  filt1,
  output logic [7:0]  filt2,
  output logic [7:0]  filt3,
  output logic [7:0]  filt4,
  output logic [7:0]  filt5,
  output logic [7:0]  filt6,
  output logic [7:0]  filt7,
  output logic        changed,
  output logic [63:0] rise_flags,
  output logic [63:0] fall_flags
);

  byte_arr_t         raw_arr;
  byte_arr_t         filt_arr;
  logic [N_BITS-1:0] filt_vec;
  logic [N_BITS-1:0] flip_vec;

  assign raw_arr = {raw7, raw6, raw5, raw4, raw3, raw2, raw1, raw0};

  for (genvar i = 0; i < N_BITS; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk         (clk),
      .rst_n       (rst_n),
      .raw         (raw_arr[i/8][i%8]),
      .sample_tick (sample_tick),
      .filt_bit    (filt_vec[i]),
      .flip_strobe (flip_vec[i])
    );
  end

  assign filt_arr = filt_vec;
  assign filt0    = filt_arr[0];
  assign filt1    = filt_arr[1];
  assign filt2    = filt_arr[2];
  assign filt3    = filt_arr[3];
  assign filt4    = filt_arr[4];
  assign filt5    = filt_arr[5];
  assign filt6    = filt_arr[6];
  assign filt7    = filt_arr[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |flip_vec;
  end

`ifdef FILTR_EDGE_DETECT_EN
  logic [N_BITS-1:0] rise_q;
  logic [N_BITS-1:0] fall_q;

  // A flip strobe is qualified by the pre-flip value to tell rise from fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= (rise_q & ~{N_BITS{scan_ack}}) | (flip_vec & ~filt_vec);
      fall_q <= (fall_q & ~{N_BITS{scan_ack}}) | (flip_vec &  filt_vec);
    end
  end

  assign rise_flags = rise_q;
  assign fall_flags = fall_q;
`else
  logic unused_scan_ack;
  assign unused_scan_ack = scan_ack;
  assign rise_flags      = '0;
  assign fall_flags      = '0;
`endif

endmodule

// File: tb/tb_filtr_wejsc.sv
// Directed bench for filtr_wejsc with a per-cycle behavioural reference model.
module tb_filtr_wejsc;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  raw0 = 8'h00, raw1 = 8'h00, raw2 = 8'h00, raw3 = 8'h00;
  logic [7:0]  raw4 = 8'h00, raw5 = 8'h00, raw6 = 8'h00, raw7 = 8'h00;
  logic        sample_tick = 1'b0;
  logic        scan_ack = 1'b0;
  logic [7:0]  filt0, filt1, filt2, filt3, filt4, filt5, filt6, filt7;
  logic        changed;
  logic [63:0] rise_flags, fall_flags;

  int checks = 0;
  int errors = 0;
  int nchg   = 0;

  filtr_wejsc dut (
    .clk(clk), .rst_n(rst_n),
    .raw0(raw0), .raw1(raw1), .raw2(raw2), .raw3(raw3),
    .raw4(raw4), .raw5(raw5), .raw6(raw6), .raw7(raw7),
    .sample_tick(sample_tick), .scan_ack(scan_ack),
    .filt0(filt0), .filt1(filt1), .filt2(filt2), .filt3(filt3),
    .filt4(filt4), .filt5(filt5), .filt6(filt6), .filt7(filt7),
    .changed(changed), .rise_flags(rise_flags), .fall_flags(fall_flags)
  );

  always #5 clk = ~clk;

  wire [63:0] raw_v  = {raw7, raw6, raw5, raw4, raw3, raw2, raw1, raw0};
  wire [63:0] filt_v = {filt7, filt6, filt5, filt4, filt3, filt2, filt1, filt0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: input seen two clocks late; a bit flips once it has
  // disagreed with its filtered value on D consecutive ticks.
  logic [63:0] d1 = '0, d2 = '0, mf = '0, mrise = '0, mfall = '0;
  logic        mchg = 1'b0;
  int          run [64];

  always @(posedge clk or negedge rst_n) begin
    logic [63:0] flips;
    if (!rst_n) begin
      d1 = '0; d2 = '0; mf = '0; mrise = '0; mfall = '0; mchg = 1'b0;
      for (int i = 0; i < 64; i++) run[i] = 0;
    end else begin
      flips = '0;
      if (sample_tick) begin
        for (int i = 0; i < 64; i++) begin
          if (d2[i] != mf[i]) begin
            run[i] = run[i] + 1;
            if (run[i] == D) begin
              flips[i] = 1'b1;
              run[i]   = 0;
            end
          end else begin
            run[i] = 0;
          end
        end
      end
      mrise = scan_ack ? (flips & ~mf) : (mrise | (flips & ~mf));
      mfall = scan_ack ? (flips &  mf) : (mfall | (flips &  mf));
      mf    = mf ^ flips;
      mchg  = |flips;
      d2    = d1;
      d1    = raw_v;
    end
  end

  always @(negedge clk) begin
    chk("cmp_filt", filt_v, mf);
    chk("cmp_changed", 64'(changed), 64'(mchg));
`ifdef FILTR_EDGE_DETECT_EN
    chk("cmp_rise", rise_flags, mrise);
    chk("cmp_fall", fall_flags, mfall);
`else
    chk("cmp_rise_zero", rise_flags, 64'h0);
    chk("cmp_fall_zero", fall_flags, 64'h0);
`endif
    if (changed === 1'b1) nchg++;
  end

  initial begin
    int n0;
    int lat;
    for (int i = 0; i < 64; i++) run[i] = 0;

    // Reset with raw0 high: full debounce time after release.
    raw0 = 8'hFF;
    sample_tick = 1'b1;
    step(3);
    chk("rst_filt0", 64'(filt0), 64'h00);
    chk("rst_changed", 64'(changed), 64'h0);
    rst_n = 1'b1;
    step(17);
    chk("lat17_filt0", 64'(filt0), 64'h00);
    step(1);
    chk("lat18_filt0", 64'(filt0), 64'hFF);
    chk("lat18_changed", 64'(changed), 64'h1);
    step(1);
    chk("lat19_changed", 64'(changed), 64'h0);

    // Glitch of 15 ticks rejected, 16 ticks accepted.
    n0 = nchg;
    raw3 = 8'h20;
    step(15);
    raw3 = 8'h00;
    step(25);
    chk("glitch15_filt3", 64'(filt3), 64'h00);
    chk("glitch15_nochg", 64'(nchg - n0), 64'h0);
    raw3 = 8'h20;
    step(16);
    raw3 = 8'h00;
    step(4);
    chk("glitch16_filt3", 64'(filt3), 64'h20);
    step(25);
    chk("glitch16_back", 64'(filt3), 64'h00);

    // Tick every 4 clk: 16th tick seeing the new value is edge 65.
    raw7 = 8'h01;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      sample_tick = (c % 4 == 0);
      step(1);
      if (filt7[0] === 1'b1) begin
        lat = c + 1;
        break;
      end
    end
    chk("gate_lat", 64'(lat), 64'd65);
    sample_tick = 1'b1;

    // Simultaneous flips in two bytes give one changed pulse.
    raw6 = 8'hFF;
    step(20);
    chk("simul_pre_f6", 64'(filt6), 64'hFF);
    n0 = nchg;
    raw1 = 8'hA5;
    raw6 = 8'h00;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (filt1 !== 8'h00) begin
        lat = c + 1;
        break;
      end
    end
    chk("simul_lat", 64'(lat), 64'd18);
    chk("simul_f1", 64'(filt1), 64'hA5);
    chk("simul_f6", 64'(filt6), 64'h00);
    step(5);
    chk("simul_one_pulse", 64'(nchg - n0), 64'h1);

    // Reset mid-count.
    raw4 = 8'hFF;
    step(10);
    rst_n = 1'b0;
    #1;
    chk("midrst_filt", filt_v, 64'h0);
    step(2);
    rst_n = 1'b1;
    step(17);
    chk("midrst_lat17", 64'(filt4), 64'h00);
    step(1);
    chk("midrst_lat18", 64'(filt4), 64'hFF);
    chk("midrst_f1", 64'(filt1), 64'hA5);

    // Edge flags.
    scan_ack = 1'b1;
    step(1);
    scan_ack = 1'b0;
    raw2 = 8'h01;
    step(18);
    raw2 = 8'h03;
    step(17);
    scan_ack = 1'b1;
    step(1);
    scan_ack = 1'b0;
    chk("edge_f2", 64'(filt2), 64'h03);
    raw2 = 8'h00;
    step(20);
`ifdef FILTR_EDGE_DETECT_EN
    chk("edge_rise16", 64'(rise_flags[16]), 64'h0);
    chk("edge_rise17", 64'(rise_flags[17]), 64'h1);
    chk("edge_fall", 64'(fall_flags[17:16]), 64'h3);
`else
    chk("edge_rise_off", rise_flags, 64'h0);
    chk("edge_fall_off", fall_flags, 64'h0);
`endif

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Catch the rise[16] set before the ack clears it, when the feature is on.
`ifdef FILTR_EDGE_DETECT_EN
  initial begin
    wait (filt2[0] === 1'b1);
    #1;
    chk("edge_rise16_set", 64'(rise_flags[16]), 64'h1);
  end
`endif

endmodule
